// File: rtl/timer_shift_count_if.sv
// rtl/timer_shift_count_if.sv - handshake bundle between the pattern detector, user and delay timer
interface timer_shift_count_if;
    logic       start_shifting;
    logic       data;
    logic       ack;
    logic [3:0] count;
    logic       counting;
    logic       done;
    logic       det_clear;

    modport master (
        output start_shifting,
        output data,
        output ack,
        input  count,
        input  counting,
        input  done,
        input  det_clear
    );

    modport slave (
        input  start_shifting,
        input  data,
        input  ack,
        output count,
        output counting,
        output done,
        output det_clear
    );
endinterface

// File: rtl/timer_shift_count.sv
// rtl/timer_shift_count.sv - captures a 4-bit serial delay, counts it down in CYCLES_PER_COUNT units, waits for ack
module timer_shift_count #(
    parameter int CYCLES_PER_COUNT = 1000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    timer_shift_count_if.slave   bus
);

    localparam int SUB_W = (CYCLES_PER_COUNT > 1) ? $clog2(CYCLES_PER_COUNT) : 1;
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CYCLES_PER_COUNT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_delay;
    logic [1:0]       r_bit_cnt;
    logic [SUB_W-1:0] r_sub;
    logic [3:0]       r_count;
    logic             r_counting;
    logic             r_done;
    logic [3:0]       w_delay_next;

    assign w_delay_next = {r_delay[2:0], bus.data};

    // Outputs are updated on the same edge as the state, so they always match r_state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_delay    <= 4'd0;
            r_bit_cnt  <= 2'd0;
            r_sub      <= '0;
            r_count    <= 4'd0;
            r_counting <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_shifting) begin
                        // First bit lands in the LSB; three more shifts carry it to the MSB.
                        r_delay   <= {3'b000, bus.data};
                        r_bit_cnt <= 2'd1;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_delay   <= w_delay_next;
                    r_bit_cnt <= 2'(r_bit_cnt + 2'd1);
                    if (r_bit_cnt == 2'd3) begin
                        r_state    <= COUNT;
                        r_sub      <= '0;
                        r_count    <= w_delay_next;
                        r_counting <= 1'b1;
                    end
                end
                COUNT: begin
                    if (r_sub == SUB_LAST) begin
                        r_sub <= '0;
                        if (r_count == 4'd0) begin
                            r_state    <= DONE;
                            r_counting <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_count <= r_count - 4'd1;
                        end
                    end else begin
                        r_sub <= r_sub + SUB_W'(1);
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        r_state   <= IDLE;
                        r_done    <= 1'b0;
                        r_bit_cnt <= 2'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // r_count reaches zero before COUNT exits and is reloaded only on COUNT entry,
    // so it reads 0 in every other state.
    assign bus.count     = r_count;
    assign bus.counting  = r_counting;
    assign bus.done      = r_done;
    assign bus.det_clear = r_done & bus.ack;

endmodule

// File: tb/tb_timer_shift_count.sv
// tb/tb_timer_shift_count.sv - scoreboard bench for timer_shift_count at CYCLES_PER_COUNT 4 and 1000
module tb_timer_shift_count;

    logic clk;
    logic reset_n;
    logic start;
    logic data;
    logic ack;
    logic sel;
    int   cpc;
    int   n_checks;
    int   n_pass;

    logic [6:0] exp_q[$];

    timer_shift_count_if bus_a ();
    timer_shift_count_if bus_b ();

    assign bus_a.start_shifting = start;
    assign bus_a.data           = data;
    assign bus_a.ack            = ack;
    assign bus_b.start_shifting = start;
    assign bus_b.data           = data;
    assign bus_b.ack            = ack;

    timer_shift_count #(.CYCLES_PER_COUNT(4)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_a)
    );

    timer_shift_count dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] obs();
        if (sel)
            return {bus_b.counting, bus_b.count, bus_b.done, bus_b.det_clear};
        return {bus_a.counting, bus_a.count, bus_a.done, bus_a.det_clear};
    endfunction

    task automatic check(input string tag, input logic [6:0] got, input logic [6:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Expected entries are {counting, count[3:0], done, det_clear}, one per cycle.
    task automatic run_op(input logic [3:0] d, input int ack_wait, input bit noise, input int abort_at);
        int n_cnt;
        int total;
        logic [6:0] e;
        start = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            data = d[i];
            if (noise) ack = i[0];
            @(posedge clk); #1;
        end
        data = 1'b0;
        ack  = 1'b0;
        n_cnt = (int'(d) + 1) * cpc;
        for (int k = 0; k < n_cnt; k++)
            exp_q.push_back({1'b1, 4'(int'(d) - k / cpc), 1'b0, 1'b0});
        for (int k = 0; k <= ack_wait; k++)
            exp_q.push_back(7'b0_0000_10);
        exp_q.push_back(7'b0_0000_11);
        exp_q.push_back(7'b0_0000_00);
        total = n_cnt + ack_wait + 3;
        for (int p = 0; p < total; p++) begin
            if (noise && p < n_cnt) begin
                ack   = 1'($urandom_range(0, 1));
                start = 1'($urandom_range(0, 1));
            end else if (p == n_cnt) begin
                ack   = 1'b0;
                start = 1'b1;
            end
            if (p == n_cnt + ack_wait + 1) ack = 1'b1;
            if (p == n_cnt + ack_wait + 2) begin
                ack   = 1'b0;
                start = 1'b0;
            end
            @(negedge clk);
            if (exp_q.size() == 0) begin
                check($sformatf("qempty_d%0h_p%0d", d, p), obs(), 7'bx);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("d%0h_p%0d", d, p), obs(), e);
            end
            if (p == abort_at) begin
                #2;
                reset_n = 1'b0;
                #1;
                check("rst_async", obs(), 7'b0);
                exp_q.delete();
                start = 1'b0;
                ack   = 1'b0;
                @(posedge clk); #1;
                check("rst_held", obs(), 7'b0);
                reset_n = 1'b1;
                @(posedge clk); #1;
                @(negedge clk);
                check("rst_release", obs(), 7'b0);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        sel      = 1'b0;
        cpc      = 4;
        start    = 1'b0;
        data     = 1'b0;
        ack      = 1'b0;
        reset_n  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_a", {bus_a.counting, bus_a.count, bus_a.done, bus_a.det_clear}, 7'b0);
        check("reset_b", {bus_b.counting, bus_b.count, bus_b.done, bus_b.det_clear}, 7'b0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        run_op(4'b1010, 10, 1'b0, -1);
        run_op(4'b0000, 0, 1'b0, -1);
        run_op(4'b0011, 1, 1'b1, -1);
        run_op(4'b1111, 0, 1'b0, -1);
        run_op(4'b0111, 0, 1'b0, 9);
        run_op(4'b1111, 2, 1'b0, -1);

        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        sel = 1'b1;
        cpc = 1000;
        @(posedge clk); #1;
        run_op(4'b0001, 2, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
